uart_rx: RTL

//  Serial receiver; the downstream partner of the UART transmitter.

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for uart_rx: the master side drives tick, line and ack,
// the slave side (uart_rx) returns the received word, its flags and status.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  os_tick;
    logic                  rx_serial;
    logic                  data_ack;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  parity_err;
    logic                  frame_err;
    logic                  overrun;
    logic                  busy;

    modport master (
        output os_tick, rx_serial, data_ack,
        input  data_out, data_valid, parity_err, frame_err, overrun, busy
    );

    modport slave (
        input  os_tick, rx_serial, data_ack,
        output data_out, data_valid, parity_err, frame_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, LSB-first data, even parity, stop; valid/ack holding register.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each bit centre.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave bus
);
    localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int START_LAST = OVERSAMPLE / 2;
`else
    localparam int START_LAST = OVERSAMPLE / 2 - 1;
`endif
    localparam logic [TW-1:0] START_LAST_C = TW'(START_LAST);
    localparam logic [TW-1:0] BIT_LAST_C   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST_C  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e                state_q;
    logic                  rx_meta_q, rx_s_q, armed_q;
    logic [TW-1:0]         tick_cnt_q;
    logic [BW-1:0]         bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  perr_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_valid_q, parity_err_q, frame_err_q, overrun_q;
    logic                  bit_val, bit_tick, in_frame_bit, commit;

    // NOTE: the synchroniser resets to the idle line level so reset release never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx_serial;
            rx_s_q    <= rx_meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // Last two os_tick samples; combined with the current one they form the centre-1/centre/centre+1 vote.
    always_ff @(posedge clk) begin
        if (rst)              hist_q <= 2'b11;
        else if (bus.os_tick) hist_q <= {hist_q[0], rx_s_q};
    end

    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
    assign bit_val = rx_s_q;
`endif

    assign in_frame_bit = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);
    assign bit_tick     = bus.os_tick && in_frame_bit && (tick_cnt_q == BIT_LAST_C);
    assign shift_d      = {bit_val, shift_q[DATA_WIDTH-1:1]};
    assign commit       = bit_tick && (state_q == STOP);

    // NOTE: all sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
        end else begin
            if (bus.os_tick && in_frame_bit)
                tick_cnt_q <= bit_tick ? '0 : tick_cnt_q + 1'b1;

            case (state_q)
                IDLE: begin
                    if (rx_s_q) armed_q <= 1'b1;
                    if (bus.os_tick && armed_q && !rx_s_q) begin
                        state_q    <= START;
                        tick_cnt_q <= '0;
                    end
                end
                START: begin
                    if (bus.os_tick) begin
                        if (tick_cnt_q == START_LAST_C) begin
                            tick_cnt_q <= '0;
                            bit_cnt_q  <= '0;
                            state_q    <= bit_val ? IDLE : DATA;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_q <= shift_d;
                        if (bit_cnt_q == DATA_LAST_C) state_q   <= PARITY;
                        else                          bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        perr_q  <= bit_val ^ (^shift_q);
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    // Disarm so a line stuck low after a bad stop bit cannot start a false frame.
                    if (bit_tick) begin
                        state_q <= IDLE;
                        armed_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (commit) begin
            data_out_q   <= shift_q;
            parity_err_q <= perr_q;
            frame_err_q  <= ~bit_val;
            data_valid_q <= 1'b1;
            if (data_valid_q && !bus.data_ack) overrun_q <= 1'b1;
        end else if (bus.data_ack && data_valid_q) begin
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
